// File: rtl/ctrl_adc_rd_pkg.sv
// ctrl_adc_rd_pkg -- shared constants for the ADC daisy-chain read controller.
//   state_t              : controller state encodings
//   ADC_WORD_BITS        : bits per ADC channel word
//   DEFAULT_CLK_DIV      : default sysclk cycles per sclk half-period
//   DEFAULT_CONV_CYCLES  : default sysclk cycles csel is held high
package ctrl_adc_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int ADC_WORD_BITS       = 16;
  localparam int DEFAULT_CLK_DIV     = 4;
  localparam int DEFAULT_CONV_CYCLES = 200;

endpackage

// File: rtl/ctrl_adc_rd_spi_rx_shift.sv
// spi_rx_shift -- sclk generator and serial receive shifter.
// While en is high it produces NUM_BITS sclk periods (CLK_DIV sysclk cycles
// low, then CLK_DIV high), samples miso MSB-first on the sysclk edge that
// drives sclk high, and flags shift_done on the cycle the last high phase ends.
// Ports:
//   sysclk     in   clock
//   reset      in   asynchronous active-low reset
//   en         in   high while the controller is in SHIFT; low clears counters
//   miso       in   serial data
//   sclk       out  serial clock, low whenever en is low
//   shift_done out  combinational: final period completes at the next edge
//   data       out  NUM_BITS received word, first bit in the MSB
module spi_rx_shift
  import ctrl_adc_rd_pkg::*;
#(
  parameter int CLK_DIV  = DEFAULT_CLK_DIV,
  parameter int NUM_BITS = 64
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic                en,
  input  logic                miso,
  output logic                sclk,
  output logic                shift_done,
  output logic [NUM_BITS-1:0] data
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [6:0] BITS_ALL = 7'(NUM_BITS);

  logic [7:0]          div_cnt_reg;
  logic                phase_reg;    // 0 = low half-period, 1 = high half-period
  logic [6:0]          bit_cnt_reg;  // saturates at NUM_BITS
  logic                sclk_reg;
  logic [NUM_BITS-1:0] shift_reg;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      div_cnt_reg <= '0;
      phase_reg   <= 1'b0;
      bit_cnt_reg <= '0;
      sclk_reg    <= 1'b0;
      shift_reg   <= '0;
    end else if (!en) begin
      div_cnt_reg <= '0;
      phase_reg   <= 1'b0;
      bit_cnt_reg <= '0;
      sclk_reg    <= 1'b0;
    end else if (div_cnt_reg == DIV_LAST) begin
      div_cnt_reg <= '0;
      phase_reg   <= ~phase_reg;
      if (!phase_reg) begin
        // Low phase ends: sclk rises and miso is captured on this same edge.
        sclk_reg <= 1'b1;
        if (bit_cnt_reg != BITS_ALL) begin
          shift_reg   <= {shift_reg[NUM_BITS-2:0], miso};
          bit_cnt_reg <= bit_cnt_reg + 7'd1;
        end
      end else begin
        sclk_reg <= 1'b0;
      end
    end else begin
      div_cnt_reg <= div_cnt_reg + 8'd1;
    end
  end

  assign shift_done = en && phase_reg && (div_cnt_reg == DIV_LAST) &&
                      (bit_cnt_reg == BITS_ALL);
  assign sclk = sclk_reg;
  assign data = shift_reg;

endmodule

// File: rtl/ctrl_adc_rd.sv
// ctrl_adc_rd -- SPI read controller for a daisy chain of CONV-started 16-bit
// ADCs. A trigger starts a conversion (csel high for CONV_CYCLES), then
// 16*NUM_CHANNELS bits are clocked in and split into adc1..adc4, announced by
// a one-cycle data_ready pulse.
// Optional build macro: ADC_AUTO_TRIG_EN -- a free-running 16-bit counter
// raises an internal trigger every AUTO_PERIOD cycles, ORed with trig.
// Ports:
//   sysclk      in   clock
//   reset       in   asynchronous active-low reset
//   trig        in   start request, sampled in IDLE only
//   sclk        out  serial clock, idles low
//   csel        out  CONV/chip-select, high = convert
//   miso        in   serial data from the chain
//   adc1..adc4  out  latest channel words (adc1 = first 16 bits received)
//   busy        out  high from trigger acceptance until data_ready
//   data_ready  out  one-cycle pulse when adc1..adc4 update
module ctrl_adc_rd
  import ctrl_adc_rd_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int CLK_DIV      = DEFAULT_CLK_DIV,
  parameter int CONV_CYCLES  = DEFAULT_CONV_CYCLES,
  parameter int AUTO_PERIOD  = 3072
) (
  input  logic                     sysclk,
  input  logic                     reset,
  input  logic                     trig,
  output logic                     sclk,
  output logic                     csel,
  input  logic                     miso,
  output logic [ADC_WORD_BITS-1:0] adc1,
  output logic [ADC_WORD_BITS-1:0] adc2,
  output logic [ADC_WORD_BITS-1:0] adc3,
  output logic [ADC_WORD_BITS-1:0] adc4,
  output logic                     busy,
  output logic                     data_ready
);

  localparam int          NUM_BITS  = ADC_WORD_BITS * NUM_CHANNELS;
  localparam logic [15:0] CONV_LAST = 16'(CONV_CYCLES - 1);

  state_t                   state_reg, state_next;
  logic [15:0]              conv_cnt_reg, conv_cnt_next;
  logic                     csel_reg, busy_reg, data_ready_reg;
  logic                     shift_done;
  logic                     auto_trig;
  logic                     start_req;
  logic [NUM_BITS-1:0]      shift_word;
  logic [ADC_WORD_BITS-1:0] chan_word [NUM_CHANNELS];
  logic [ADC_WORD_BITS-1:0] adc_reg   [NUM_CHANNELS];

`ifdef ADC_AUTO_TRIG_EN
  localparam logic [15:0] AUTO_LAST = 16'(AUTO_PERIOD - 1);

  logic [15:0] auto_cnt_reg;
  logic        auto_trig_reg;

  // Free-runs regardless of busy; a pulse landing outside IDLE is simply lost.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      auto_cnt_reg  <= '0;
      auto_trig_reg <= 1'b0;
    end else if (auto_cnt_reg == AUTO_LAST) begin
      auto_cnt_reg  <= '0;
      auto_trig_reg <= 1'b1;
    end else begin
      auto_cnt_reg  <= auto_cnt_reg + 16'd1;
      auto_trig_reg <= 1'b0;
    end
  end

  assign auto_trig = auto_trig_reg;
`else
  // AUTO_PERIOD only matters when the auto-trigger is built; referencing it
  // here keeps the parameter live without creating any logic.
  localparam logic AUTO_PERIOD_OK = (AUTO_PERIOD >= 1) && (AUTO_PERIOD <= 65535);
  assign auto_trig = 1'b0 & AUTO_PERIOD_OK;
`endif

  assign start_req = trig | auto_trig;

  spi_rx_shift #(
    .CLK_DIV  (CLK_DIV),
    .NUM_BITS (NUM_BITS)
  ) u_spi_rx_shift (
    .sysclk     (sysclk),
    .reset      (reset),
    .en         (state_reg == ST_SHIFT),
    .miso       (miso),
    .sclk       (sclk),
    .shift_done (shift_done),
    .data       (shift_word)
  );

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      conv_cnt_reg   <= '0;
      csel_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      data_ready_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      conv_cnt_reg   <= conv_cnt_next;
      // Outputs are decoded from the next state so they are registered and
      // line up with the state they describe.
      csel_reg       <= (state_next == ST_CONV);
      busy_reg       <= (state_next == ST_CONV) || (state_next == ST_SHIFT);
      data_ready_reg <= (state_next == ST_DONE);
    end
  end

  always_comb begin
    state_next    = state_reg;
    conv_cnt_next = conv_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        conv_cnt_next = '0;
        if (start_req) state_next = ST_CONV;
      end
      ST_CONV: begin
        if (conv_cnt_reg == CONV_LAST) state_next = ST_SHIFT;
        else                           conv_cnt_next = conv_cnt_reg + 16'd1;
      end
      ST_SHIFT: begin
        if (shift_done) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Split the received word: channel 0 is the first word shifted in (MSBs).
  // The shift register is final by the edge that enters DONE, so outputs are
  // latched there and are visible together with data_ready.
  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
    assign chan_word[gi] =
      shift_word[(NUM_CHANNELS - gi) * ADC_WORD_BITS - 1 -: ADC_WORD_BITS];

    always_ff @(posedge sysclk or negedge reset) begin
      if (!reset)                      adc_reg[gi] <= '0;
      else if (state_next == ST_DONE)  adc_reg[gi] <= chan_word[gi];
    end
  end

  assign adc1       = adc_reg[0];
  assign adc2       = adc_reg[1];
  assign adc3       = adc_reg[2];
  assign adc4       = adc_reg[3];
  assign csel       = csel_reg;
  assign busy       = busy_reg;
  assign data_ready = data_ready_reg;

endmodule

// File: tb/tb_ctrl_adc_rd.sv
// tb_ctrl_adc_rd -- scoreboard bench for ctrl_adc_rd with default parameters.
// Stimulus pushes the serial word a model ADC chain will return and the
// expected result (words and data_ready cycle) into queues; a monitor on the
// falling clock edge drives miso, counts sclk/csel activity, and pops and
// compares whenever data_ready is seen.
module tb_ctrl_adc_rd;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b0;
  logic        trig   = 1'b0;
  logic        miso   = 1'b0;
  logic        sclk, csel, busy, data_ready;
  logic [15:0] adc1, adc2, adc3, adc4;

  ctrl_adc_rd dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .trig       (trig),
    .sclk       (sclk),
    .csel       (csel),
    .miso       (miso),
    .adc1       (adc1),
    .adc2       (adc2),
    .adc3       (adc3),
    .adc4       (adc4),
    .busy       (busy),
    .data_ready (data_ready)
  );

  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] word;
    int          dr_cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] tx_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          dr_count = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / model ADC chain ----------------
  logic        sclk_p = 1'b0, csel_p = 1'b0, dr_p = 1'b0;
  logic [63:0] tx_cur = '0;
  int          bit_idx = 0, rises = 0, csel_cyc = 0;
  exp_t        mon_e;

  always @(negedge sysclk) begin
    if (!reset) begin
      sclk_p = 1'b0;
      csel_p = 1'b0;
      dr_p   = 1'b0;
    end else begin
      if (csel && !csel_p) begin
        csel_cyc = 0;
        rises    = 0;
        tx_cur   = (tx_q.size() > 0) ? tx_q.pop_front() : 64'h0;
      end
      if (csel) csel_cyc++;
      if (!csel && csel_p) begin
        bit_idx = 63;
        miso    = tx_cur[63];
      end
      if (sclk && !sclk_p) begin
        rises++;
        if (bit_idx > 0) begin
          bit_idx--;
          miso = tx_cur[bit_idx];
        end
      end
      if (dr_p) check("data_ready_width", {71'd0, data_ready}, 72'd0);
      if (data_ready) begin
        dr_count++;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_data_ready: got pulse expected none (cycle %0d)", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          $display("transfer done at cycle %0d: adc=%h %h %h %h", cyc, adc1, adc2, adc3, adc4);
          check("adc1", {56'd0, adc1}, {56'd0, mon_e.word[63:48]});
          check("adc2", {56'd0, adc2}, {56'd0, mon_e.word[47:32]});
          check("adc3", {56'd0, adc3}, {56'd0, mon_e.word[31:16]});
          check("adc4", {56'd0, adc4}, {56'd0, mon_e.word[15:0]});
          check("dr_cycle", 72'(cyc), 72'(mon_e.dr_cyc));
          check("sclk_rises", 72'(rises), 72'd64);
          check("csel_cycles", 72'(csel_cyc), 72'd200);
          check("busy_at_done", {71'd0, busy}, 72'd0);
        end
      end
      sclk_p = sclk;
      csel_p = csel;
      dr_p   = data_ready;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  // Call just after a rising edge; trig is high for this one cycle.
  task automatic issue(input logic [63:0] w);
    tx_q.push_back(w);
    sb_q.push_back('{word: w, dr_cyc: cyc + 713});
    trig = 1'b1;
    @(posedge sysclk);
    #1;
    trig = 1'b0;
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    @(posedge sysclk);
    #1;
    trig = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {sclk, csel, busy, data_ready, adc1, adc2, adc3, adc4}, 72'd0);
  endtask

  int c, d0;

  initial begin
    repeat (3) @(posedge sysclk);
    #1 reset = 1'b1;

    // Idle after reset: nothing moves without trig.
    for (int i = 0; i < 1000; i++) begin
      @(negedge sysclk);
      check_all_zero("idle_after_reset");
    end
    @(posedge sysclk);
    #1;

    // Single transfer with boundary data patterns.
    c = cyc;
    issue(64'h1234_8000_FFFF_0001);
    wait_until(c + 720);
    check("single_drained", 72'(sb_q.size()), 72'd0);

    // Triggers during a transfer are ignored.
    c  = cyc;
    d0 = dr_count;
    issue(64'hA5A5_5A5A_0F0F_F0F0);
    wait_until(c + 10);
    pulse_trig();
    wait_until(c + 500);
    pulse_trig();
    wait_until(c + 730);
    check("ignored_trig_drained", 72'(sb_q.size()), 72'd0);
    check("ignored_trig_dr_count", 72'(dr_count - d0), 72'd1);

    // Reset mid-SHIFT aborts and clears outputs immediately.
    c = cyc;
    issue(64'hDEAD_BEEF_CAFE_F00D);
    wait_until(c + 400);
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid_shift_immediate");
    void'(sb_q.pop_back());
    @(negedge sysclk);
    check_all_zero("reset_mid_shift_held");
    @(posedge sysclk);
    #1 reset = 1'b1;
    @(posedge sysclk);
    #1;
    c = cyc;
    issue(64'h0001_0002_0004_0008);
    wait_until(c + 720);
    check("after_reset_drained", 72'(sb_q.size()), 72'd0);

    // trig held high: back-to-back transfers every 714 cycles.
    c = cyc;
    tx_q.push_back(64'h1357_2468_9ABC_DEF0);
    tx_q.push_back(64'hFEDC_BA98_7654_3210);
    tx_q.push_back(64'h8001_4002_2004_1008);
    sb_q.push_back('{word: 64'h1357_2468_9ABC_DEF0, dr_cyc: c + 713});
    sb_q.push_back('{word: 64'hFEDC_BA98_7654_3210, dr_cyc: c + 1427});
    sb_q.push_back('{word: 64'h8001_4002_2004_1008, dr_cyc: c + 2141});
    trig = 1'b1;
    wait_until(c + 2141);
    trig = 1'b0;
    wait_until(c + 2160);
    check("held_trig_drained", 72'(sb_q.size()), 72'd0);
    check_all_zero_ctrl();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic check_all_zero_ctrl();
    check("final_idle_ctrl", {68'd0, sclk, csel, busy, data_ready}, 72'd0);
  endtask

  initial begin
    #500000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected test completion (cycle %0d)", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_adc_rd.md
# ctrl_adc_rd

SPI read controller for a daisy chain of `NUM_CHANNELS` 16-bit ADCs (LTC1864-class, CONV-pin started) on the QLA board. It is the read-side counterpart to the DAC write path. On a trigger it starts a conversion, clocks the combined serial bitstream back in, and splits it into per-channel words. It then presents those words to the host/control logic with a one-cycle `data_ready` pulse.

## Interface
Parameters:
- `NUM_CHANNELS`, default 4: ADCs in the chain; channel outputs fixed at four ports, and the RTL supports only 4.
- `CLK_DIV`, default 4: sysclk cycles per sclk half-period; legal range 1..255.
- `CONV_CYCLES`, default 200: sysclk cycles `csel` is held high for conversion; legal range 1..65535.
- `AUTO_PERIOD`, default 3072: auto-trigger period in sysclk cycles; used only with `ADC_AUTO_TRIG_EN`.

Ports:
- `sysclk`  in  1  global clock
- `reset`  in  1  asynchronous, active-low reset
- `trig`  in  1  start request, level-sampled each cycle
- `sclk`  out  1  serial clock, idles low
- `csel`  out  1  CONV/chip-select; high = convert, low = read
- `miso`  in  1  serial data from the chain
- `adc1`..`adc4`  out  16 each  latest channel words
- `busy`  out  1  high from trigger acceptance until `data_ready`
- `data_ready`  out  1  one-cycle pulse when `adc1`..`adc4` update

## Operation
- States: IDLE -> CONV -> SHIFT -> DONE -> IDLE.
- IDLE
  - `trig`=1 accepts the request: next cycle is CONV, `csel`=1, `busy`=1.
  - `trig` arriving in any other state is ignored; it is not queued.
- CONV
  - 16-bit counter runs `CONV_CYCLES`, then `csel` goes 0 and the state moves to SHIFT.
- SHIFT
  - Runs 16*`NUM_CHANNELS` sclk periods. Each period is `CLK_DIV` cycles low, then `CLK_DIV` cycles high.
  - `miso` is sampled on the sysclk edge where `sclk` rises, into a 64-bit shift register, MSB first.
  - Bit counter is 7 bits and stops at 64; no wrap.
- DONE, one cycle
  - Bits [63:48] go to `adc1`, [47:32] to `adc2`, [31:16] to `adc3`, [15:0] to `adc4`.
  - `data_ready`=1, `busy`=0, then IDLE.
- Outputs hold their values until the next DONE; a partial transfer never updates them.
- `sclk` is low in IDLE, CONV and DONE.
- Reset (any state, asynchronous) values:
  - state=IDLE
  - `sclk`=0, `csel`=0, `busy`=0, `data_ready`=0
  - `adc1`..`adc4`=16'h0000
  - shift register and all counters cleared
  - A transfer in progress is aborted and outputs are not updated.

## Timing
- Trigger accepted at cycle T. Then:
  - `csel` high for cycles T+1 .. T+`CONV_CYCLES`.
  - SHIFT spans 128*`CLK_DIV` cycles.
  - `data_ready` and the output update occur at T+`CONV_CYCLES`+128*`CLK_DIV`+1. With defaults: T+713.
- Back-to-back operation: `trig` held high restarts at the cycle after DONE.
  - Minimum trigger period = `CONV_CYCLES`+128*`CLK_DIV`+2 cycles.
- First sclk rising edge occurs `CLK_DIV` cycles after `csel` falls.
- `miso` is sampled at the same sysclk edge that drives `sclk` high. The bench must present the bit at least 1 cycle before that edge.

## Configuration
- `ADC_AUTO_TRIG_EN` defined:
  - Internal 16-bit counter raises an internal trigger every `AUTO_PERIOD` cycles.
  - The internal trigger is ORed with `trig`.
  - The counter resets to 0 on `reset` and free-runs regardless of `busy`.
  - An internal trigger that fires while busy is dropped.
- Not defined: only `trig` starts a transfer, and the counter logic is absent.

## Structure
- Shared constants package holds:
  - state encodings: IDLE=2'd0, CONV=2'd1, SHIFT=2'd2, DONE=2'd3
  - `ADC_WORD_BITS`=16
  - default `CLK_DIV`/`CONV_CYCLES`
- One sub-module, `spi_rx_shift`:
  - Generates sclk from `CLK_DIV`, samples `miso`, counts bits.
  - Reports `shift_done` and the 64-bit word.
  - The top level owns the FSM, the conversion counter, and output latching.

## Test plan
- Reset release, no trig for 1000 cycles -> `sclk`/`csel`/`busy`/`data_ready`=0, all `adc`=0.
- Single trig, model returns 16'h1234, 16'h8000, 16'hFFFF, 16'h0001 -> at T+713:
  - `adc1`..`adc4` equal those values
  - `data_ready` high exactly 1 cycle
  - 64 sclk rising edges seen
  - `csel` high 200 cycles
- trig pulses at T+10 and T+500 during a transfer -> ignored; exactly one `data_ready`.
- `reset` asserted at T+400, mid-SHIFT -> outputs immediately at reset values; the next trig gives a clean full transfer.
- `trig` held high for 3 transfers with distinct data -> `data_ready` spacing 714 cycles; each transfer's data is correct.
- `ADC_AUTO_TRIG_EN`, `AUTO_PERIOD`=1000, `trig`=0 -> `data_ready` every 1000 cycles, first at cycle 1000+713 after reset.
